// File: rtl/filter_peak_scanner.sv
// Test sequencer for the filter bench: triggers the generator, waits out the pipeline,
// captures per-channel signed peak and time-of-peak, then streams results over valid/ready.
module filter_peak_scanner #(
  parameter int unsigned NUM_CH           = 21,
  parameter int unsigned SIZE_FILTER_DATA = 16,
  parameter int unsigned SIZE_DELAY       = 8,
  parameter int unsigned SKIP             = 4,
  parameter int unsigned WINDOW           = 64,
  parameter int unsigned SIZE_CH          = $clog2(NUM_CH),
  parameter int unsigned SIZE_T           = $clog2(WINDOW)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               cfg_overlay,
  input  logic [SIZE_DELAY-1:0]              cfg_delay,
  output logic                               test_overlay,
  output logic                               test_rate,
  output logic [SIZE_DELAY-1:0]              test_delay,
  input  logic [NUM_CH*SIZE_FILTER_DATA-1:0] filter_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [SIZE_CH-1:0]                 res_ch,
  output logic [SIZE_FILTER_DATA-1:0]        res_peak,
  output logic [SIZE_T-1:0]                  res_time,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned W      = SIZE_FILTER_DATA;
  localparam int unsigned SKIP_W = 8;
  localparam logic signed [W-1:0] PEAK_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_CAPTURE, S_REPORT, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SKIP_W-1:0]     skip_q, skip_d;
  logic [SIZE_T-1:0]     n_q, n_d;
  logic [SIZE_CH-1:0]    ch_q, ch_d;
  logic                  overlay_d;
  logic [SIZE_DELAY-1:0] delay_d;
  logic signed [W-1:0]   peak_q [NUM_CH];
  logic signed [W-1:0]   peak_d [NUM_CH];
  logic [SIZE_T-1:0]     time_q [NUM_CH];
  logic [SIZE_T-1:0]     time_d [NUM_CH];

  logic                  test_rate_d, res_valid_d, busy_d, done_d;
  logic [SIZE_CH-1:0]    res_ch_d;
  logic [W-1:0]          res_peak_d;
  logic [SIZE_T-1:0]     res_time_d;
  logic                  xfer;

  assign xfer = res_valid & res_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && !abort) state_d = S_ARM;
      S_ARM:     state_d = S_WAIT;
      S_WAIT:    if (skip_q == '0) state_d = S_CAPTURE;
      S_CAPTURE: if (n_q == SIZE_T'(WINDOW - 1)) state_d = S_REPORT;
      S_REPORT:  if (xfer && ch_q == SIZE_CH'(NUM_CH - 1)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Datapath next values and registered-output next values
  always_comb begin
    skip_d    = skip_q;
    n_d       = n_q;
    ch_d      = ch_q;
    overlay_d = test_overlay;
    delay_d   = test_delay;
    peak_d    = peak_q;
    time_d    = time_q;

    if (state_q == S_IDLE && state_d == S_ARM) begin
      overlay_d = cfg_overlay;
      delay_d   = cfg_delay;
    end

    case (state_q)
      S_ARM: begin
        skip_d = SKIP_W'(SKIP - 1);
        n_d    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          peak_d[k] = PEAK_MIN;
          time_d[k] = '0;
        end
      end
      S_WAIT: if (skip_q != '0) skip_d = skip_q - SKIP_W'(1);
      S_CAPTURE: begin
        // Strict compare keeps the earliest index on ties
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if ($signed(filter_data[k*W +: W]) > peak_q[k]) begin
            peak_d[k] = $signed(filter_data[k*W +: W]);
            time_d[k] = n_q;
          end
        end
        n_d  = n_q + SIZE_T'(1);
        ch_d = '0;
      end
      S_REPORT: if (xfer && ch_q != SIZE_CH'(NUM_CH - 1)) ch_d = ch_q + SIZE_CH'(1);
      default: ;
    endcase

    test_rate_d = (state_d == S_ARM);
    res_valid_d = (state_d == S_REPORT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    res_ch_d    = '0;
    res_peak_d  = '0;
    res_time_d  = '0;
    if (state_d == S_REPORT) begin
      res_ch_d   = ch_d;
      res_peak_d = peak_d[ch_d];
      res_time_d = time_d[ch_d];
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_q       <= '0;
      n_q          <= '0;
      ch_q         <= '0;
      test_overlay <= 1'b0;
      test_delay   <= '0;
      test_rate    <= 1'b0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      res_ch       <= '0;
      res_peak     <= '0;
      res_time     <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        peak_q[k] <= '0;
        time_q[k] <= '0;
      end
    end else begin
      skip_q       <= skip_d;
      n_q          <= n_d;
      ch_q         <= ch_d;
      test_overlay <= overlay_d;
      test_delay   <= delay_d;
      test_rate    <= test_rate_d;
      res_valid    <= res_valid_d;
      busy         <= busy_d;
      done         <= done_d;
      res_ch       <= res_ch_d;
      res_peak     <= res_peak_d;
      res_time     <= res_time_d;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        peak_q[k] <= peak_d[k];
        time_q[k] <= time_d[k];
      end
    end
  end

endmodule

// File: tb/tb_filter_peak_scanner.sv
// Bench for filter_peak_scanner: run-timeline model with per-cycle compare plus literal checks.
module tb_filter_peak_scanner;

  localparam int NUM_CH = 21;
  localparam int W      = 16;
  localparam int SKIP   = 4;
  localparam int WINDOW = 64;
  localparam int LAT    = 2 + SKIP + WINDOW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              cfg_overlay = 1'b0;
  logic [7:0]        cfg_delay = 8'h00;
  logic              test_overlay, test_rate;
  logic [7:0]        test_delay;
  logic [NUM_CH*W-1:0] filter_data = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [4:0]        res_ch;
  logic [W-1:0]      res_peak;
  logic [5:0]        res_time;
  logic              busy, done;

  filter_peak_scanner dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_overlay(cfg_overlay), .cfg_delay(cfg_delay),
    .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
    .filter_data(filter_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_peak(res_peak), .res_time(res_time), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus samples and the expected peak/time derived from them
  logic [W-1:0] smp [NUM_CH][WINDOW];
  logic [W-1:0] exp_peak [NUM_CH];
  logic [5:0]   exp_time [NUM_CH];
  int           ready_mode = 0;

  function automatic logic [W-1:0] gen(input int pat, input int k, input int n);
    int v;
    if (pat == 0) return W'(n * (k + 1));
    case (k)
      0:       v = -5;
      1:       v = (n == 7 || n == 30) ? 100 : -1;
      2:       v = -32768;
      default: v = ((k * 37 + n * 53) % 211) - 105;
    endcase
    return W'(v);
  endfunction

  task automatic load(input int pat);
    logic signed [W-1:0] best;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int n = 0; n < WINDOW; n++) smp[k][n] = gen(pat, k, n);
      best = $signed(smp[k][0]);
      exp_time[k] = 6'd0;
      for (int n = 1; n < WINDOW; n++)
        if ($signed(smp[k][n]) > best) begin
          best = $signed(smp[k][n]);
          exp_time[k] = 6'(n);
        end
      exp_peak[k] = best;
    end
  endtask

  // Run-timeline model: cycle count since start, results handed over so far
  int   m_cyc = 0;
  int   m_idx = 0;
  logic m_active = 1'b0;
  logic m_done = 1'b0;
  logic m_ovl = 1'b0;
  logic [7:0] m_dly = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0; m_done <= 1'b0; m_cyc <= 0; m_idx <= 0;
      m_ovl <= 1'b0; m_dly <= 8'h00;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (!m_done && start && !abort) begin
          m_active <= 1'b1; m_cyc <= 1; m_idx <= 0;
          m_ovl <= cfg_overlay; m_dly <= cfg_delay;
        end
      end else if (abort) begin
        m_active <= 1'b0;
      end else if (m_cyc < LAT) begin
        m_cyc <= m_cyc + 1;
      end else if (res_ready) begin
        if (m_idx == NUM_CH - 1) begin
          m_active <= 1'b0; m_done <= 1'b1;
        end else m_idx <= m_idx + 1;
      end
    end
  end

  // Data and ready driver
  initial begin
    int rcnt;
    int n;
    logic [NUM_CH*W-1:0] fd;
    rcnt = 0;
    forever begin
      @(posedge clk); #1;
      rcnt++;
      res_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 4 == 0) || (rcnt % 4 == 3));
      n  = m_cyc - SKIP - 2;
      fd = '0;
      if (m_active && n >= 0 && n < WINDOW)
        for (int k = 0; k < NUM_CH; k++) fd[k*W +: W] = smp[k][n];
      filter_data = fd;
    end
  end

  // Per-cycle compare against the model, plus transfer log
  logic [W-1:0] log_peak [32];
  logic [5:0]   log_time [32];
  int           xfer_cnt = 0;
  int           done_cnt = 0;

  initial begin
    logic pv, pr;
    logic [4:0] pch;
    logic [W-1:0] ppk;
    logic [5:0] ptm;
    logic exp_valid;
    pv = 1'b0; pr = 1'b0; pch = '0; ppk = '0; ptm = '0;
    forever begin
      @(negedge clk);
      exp_valid = m_active && (m_cyc == LAT);
      chk("busy", 32'(busy), 32'(m_active || m_done));
      chk("test_rate", 32'(test_rate), 32'(m_active && m_cyc == 1));
      chk("res_valid", 32'(res_valid), 32'(exp_valid));
      chk("done", 32'(done), 32'(m_done));
      chk("test_overlay", 32'(test_overlay), 32'(m_ovl));
      chk("test_delay", 32'(test_delay), 32'(m_dly));
      if (exp_valid) begin
        chk("res_ch", 32'(res_ch), 32'(m_idx));
        chk("res_peak", 32'(res_peak), 32'(exp_peak[m_idx]));
        chk("res_time", 32'(res_time), 32'(exp_time[m_idx]));
      end
      if (pv && !pr && res_valid) begin
        chk("stall_ch", 32'(res_ch), 32'(pch));
        chk("stall_peak", 32'(res_peak), 32'(ppk));
        chk("stall_time", 32'(res_time), 32'(ptm));
      end
      if (reset && res_valid && res_ready) begin
        log_peak[res_ch] = res_peak;
        log_time[res_ch] = res_time;
        xfer_cnt++;
      end
      if (done) done_cnt++;
      pv = res_valid; pr = res_ready; pch = res_ch; ppk = res_peak; ptm = res_time;
    end
  end

  task automatic run_full(input logic ovl, input logic [7:0] dly, input int stray,
                          output int lat, output int rc, output int dn, output int nx);
    int base;
    base = xfer_cnt;
    lat = -1; rc = 0; dn = 0;
    start = 1'b1; cfg_overlay = ovl; cfg_delay = dly;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = (c == stray);
      cfg_overlay = 1'b0; cfg_delay = 8'h00;
      @(negedge clk);
      if (test_rate) rc++;
      if (res_valid && lat < 0) lat = c + 1;
      if (done) begin dn = 1; break; end
    end
    start = 1'b0;
    nx = xfer_cnt - base;
  endtask

  initial begin
    int lat, rc, dn, nx, d0, x0, waited;
    load(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_delay", 32'(test_delay), 32'd0);
    reset = 1'b1;

    // Reset asserted mid-capture at sample 10
    @(posedge clk); #1;
    start = 1'b1; cfg_overlay = 1'b1; cfg_delay = 8'h11;
    @(posedge clk); #1;
    start = 1'b0; cfg_overlay = 1'b0; cfg_delay = 8'h00;
    waited = 0;
    while (!(m_active && m_cyc == SKIP + 12) && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    chk("reach_capture", 32'(waited < 100), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_rate", 32'(test_rate), 32'd0);
    chk("midrst_overlay", 32'(test_overlay), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Nominal ramp run
    @(posedge clk); #1;
    run_full(1'b0, 8'h00, -1, lat, rc, dn, nx);
    chk("nom_latency", 32'(lat), 32'd70);
    chk("nom_rate_pulses", 32'(rc), 32'd1);
    chk("nom_done", 32'(dn), 32'd1);
    chk("nom_xfers", 32'(nx), 32'd21);
    chk("nom_peak0", 32'(log_peak[0]), 32'd63);
    chk("nom_time0", 32'(log_time[0]), 32'd63);
    chk("nom_peak20", 32'(log_peak[20]), 32'd1323);
    chk("nom_time20", 32'(log_time[20]), 32'd63);

    // Ties, negatives and backpressure
    load(1);
    ready_mode = 1;
    @(posedge clk); #1;
    run_full(1'b0, 8'h05, -1, lat, rc, dn, nx);
    ready_mode = 0;
    chk("bp_done", 32'(dn), 32'd1);
    chk("bp_xfers", 32'(nx), 32'd21);
    chk("tie_peak0", 32'(log_peak[0]), 32'h0000_FFFB);
    chk("tie_time0", 32'(log_time[0]), 32'd0);
    chk("tie_peak1", 32'(log_peak[1]), 32'd100);
    chk("tie_time1", 32'(log_time[1]), 32'd7);
    chk("tie_peak2", 32'(log_peak[2]), 32'h0000_8000);
    chk("tie_time2", 32'(log_time[2]), 32'd0);

    // Config latch held through DONE and IDLE; stray start in REPORT ignored
    load(0);
    @(posedge clk); #1;
    run_full(1'b1, 8'h2A, 72, lat, rc, dn, nx);
    chk("cfg_done", 32'(dn), 32'd1);
    chk("cfg_xfers", 32'(nx), 32'd21);
    chk("cfg_ovl_done", 32'(test_overlay), 32'd1);
    chk("cfg_dly_done", 32'(test_delay), 32'h2A);
    @(negedge clk);
    chk("cfg_ovl_idle", 32'(test_overlay), 32'd1);
    chk("cfg_dly_idle", 32'(test_delay), 32'h2A);
    chk("cfg_idle_busy", 32'(busy), 32'd0);

    // start together with abort in IDLE stays idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("startabort_busy", 32'(busy), 32'd0);

    // Abort in REPORT after 5 transfers
    d0 = done_cnt; x0 = xfer_cnt;
    @(posedge clk); #1;
    start = 1'b1; cfg_overlay = 1'b0; cfg_delay = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!(m_active && m_cyc == LAT && m_idx == 5) && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    chk("reach_report5", 32'(waited < 200), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_xfers", 32'(xfer_cnt - x0), 32'd6);
    @(posedge clk); #1;
    run_full(1'b0, 8'h00, -1, lat, rc, dn, nx);
    chk("post_abort_done", 32'(dn), 32'd1);
    chk("post_abort_xfers", 32'(nx), 32'd21);
    chk("post_abort_latency", 32'(lat), 32'd70);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
